regfile_bypass_sb: RTL and testbench
====================================

// Module: regfile_bypass_sb
// PURPOSE
//  Parametrised multi-ported register file for the pipelined MIPS datapath:
//  two read ports (A/B), one write port, optional hardwired-zero register.
//  Same-cycle write-to-read bypass and an optional registered-read mode.
//  A per-register pending-write scoreboard flags read-after-write hazards
//  to the decode/stall logic.
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width; depth = 2**AW registers
//  ZERO_REG  1   1: register 0 always reads 0, writes and issues to it ignored
//  READ_REG  0   0: combinational read (latency 0); 1: registered A/B (latency 1)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  rs         in   AW   read address, port A
//  rt         in   AW   read address, port B
//  rd         in   AW   write address
//  writedata  in   DW   write data
//  regwrite   in   1    write enable, sampled at posedge clk
//  issue_vld  in   1    instruction issued with a destination; marks issue_rd pending
//  issue_rd   in   AW   destination of the issued instruction
//  A          out  DW   read data, port A
//  B          out  DW   read data, port B
//  hazard_a   out  1    rs has an outstanding write not satisfied by the bypass
//  hazard_b   out  1    rt has an outstanding write not satisfied by the bypass
// BEHAVIOUR
//  Reset (rst_n=0, async, takes effect immediately, including mid-operation):
//   - all 2**AW registers = 0; all pending bits = 0.
//   - READ_REG=1: A = B = 0. READ_REG=0: A/B follow the cleared array.
//   - hazard_a = hazard_b = 0.
//  Write: at posedge, if regwrite=1 and not (ZERO_REG=1 and rd=0), reg[rd] <= writedata.
//  Read value, port A (port B identical with rt):
//   - if rs=0 and ZERO_REG=1: 0.
//   - else if regwrite=1 and rd=rs: writedata (bypass, write-first).
//   - else reg[rs].
//   - READ_REG=0: A is this value combinationally.
//   - READ_REG=1: A <= this value at posedge; one-cycle latency.
//  Scoreboard (pend[2**AW-1:0]), updated at posedge:
//   - a valid write (as above) clears pend[rd].
//   - issue_vld=1 with a valid issue_rd sets pend[issue_rd].
//   - same register written and issued in one cycle: set wins (new producer).
//   - issue to an already-pending register: stays set, no count kept.
//   - ZERO_REG=1: pend[0] is constant 0.
//  Hazard (combinational, both READ_REG modes):
//   - hazard_a = pend[rs] & ~(regwrite & rd=rs); hazard_b likewise with rt.
//   - a write arriving this cycle satisfies the hazard through the bypass.
//  Simultaneous events: both ports may read the same address; rs=rt=rd with
//   regwrite returns writedata on both. The write and the scoreboard update
//   complete in the same edge. rst_n deassertion is synchronised by the
//   instantiating block.
//  Width rule: no arithmetic; writedata is stored unmodified at DW bits.
// TESTING
//  T1 reset: rst_n=0 -> A=B=0, hazards 0; after release, read rs=7,rt=31 -> 0,0.
//  T2 write/read: regwrite=1,rd=3,writedata=100; next cycle rt=3 -> B=100
//     (READ_REG=1: one cycle later); rs=3 in the write cycle -> A=100 via bypass.
//  T3 zero reg: regwrite=1,rd=0,writedata=100; then rs=0 -> A=0;
//     issue_vld,issue_rd=0 -> hazard_a stays 0.
//  T4 scoreboard: issue_vld,issue_rd=6; next cycle rs=6 -> hazard_a=1;
//     regwrite,rd=6,writedata=100 -> hazard_a=0 that cycle, A=100;
//     next cycle pend[6]=0.
//  T5 set-wins: regwrite,rd=5 and issue_vld,issue_rd=5 on the same edge
//     -> following cycle rt=5 gives hazard_b=1.
//  T6 async reset mid-op: pend[4]=1, reg[4]=55; pull rst_n low between edges
//     -> hazard and A (rs=4) go 0 before the next clk edge.

Source files
------------

// File: rtl/regfile_bypass_sb_if.sv
// Register file access bundle: read ports, write port, issue port
// and the hazard flags returned to decode.
interface regfile_bypass_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [DW-1:0] writedata;
  logic          regwrite;
  logic          issue_vld;
  logic [AW-1:0] issue_rd;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          hazard_a;
  logic          hazard_b;

  modport master (
    output rs, rt, rd, writedata, regwrite,
    output issue_vld, issue_rd,
    input  A, B, hazard_a, hazard_b
  );

  modport slave (
    input  rs, rt, rd, writedata, regwrite,
    input  issue_vld, issue_rd,
    output A, B, hazard_a, hazard_b
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Two-read/one-write register file with write-first bypass,
// optional registered reads and a pending-write scoreboard.
module regfile_bypass_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0
) (
  input logic                clk,
  input logic                rst_n,
  regfile_bypass_sb_if.slave bus
);
  localparam int N = 1 << AW;

  logic [DW-1:0] mem [N];
  logic [N-1:0]  pend;
  logic          wr_ok;
  logic          iss_ok;
  logic          byp_a;
  logic          byp_b;
  logic [DW-1:0] val_a;
  logic [DW-1:0] val_b;

  assign wr_ok  = bus.regwrite &
                  ~((ZERO_REG != 0) && (bus.rd == '0));
  assign iss_ok = bus.issue_vld &
                  ~((ZERO_REG != 0) && (bus.issue_rd == '0));
  assign byp_a  = bus.regwrite && (bus.rd == bus.rs);
  assign byp_b  = bus.regwrite && (bus.rd == bus.rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.rd] <= bus.writedata;
    end
  end

  // Set after clear: a same-edge issue is the newer producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (wr_ok) begin
        pend[bus.rd] <= 1'b0;
      end
      if (iss_ok) begin
        pend[bus.issue_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    val_a = mem[bus.rs];
    if ((ZERO_REG != 0) && (bus.rs == '0)) begin
      val_a = '0;
    end else if (byp_a) begin
      val_a = bus.writedata;
    end
  end

  always_comb begin
    val_b = mem[bus.rt];
    if ((ZERO_REG != 0) && (bus.rt == '0)) begin
      val_b = '0;
    end else if (byp_b) begin
      val_b = bus.writedata;
    end
  end

  assign bus.hazard_a = pend[bus.rs] & ~byp_a;
  assign bus.hazard_b = pend[bus.rt] & ~byp_b;

  generate
    if (READ_REG != 0) begin : g_rreg
      logic [DW-1:0] a_q;
      logic [DW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= val_a;
          b_q <= val_b;
        end
      end

      assign bus.A = a_q;
      assign bus.B = b_q;
    end else begin : g_rcomb
      assign bus.A = val_a;
      assign bus.B = val_b;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: combinational and registered-read
// instances driven in lockstep against an array/scoreboard model.
module tb_regfile_bypass_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_bypass_sb_if #(.DW(DW), .AW(AW)) b0 ();
  regfile_bypass_sb_if #(.DW(DW), .AW(AW)) b1 ();

  assign b1.rs        = b0.rs;
  assign b1.rt        = b0.rt;
  assign b1.rd        = b0.rd;
  assign b1.writedata = b0.writedata;
  assign b1.regwrite  = b0.regwrite;
  assign b1.issue_vld = b0.issue_vld;
  assign b1.issue_rd  = b0.issue_rd;

  regfile_bypass_sb #(
    .DW(DW), .AW(AW), .ZERO_REG(1), .READ_REG(0)
  ) u_comb (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  regfile_bypass_sb #(
    .DW(DW), .AW(AW), .ZERO_REG(1), .READ_REG(1)
  ) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg [N];
  bit            m_pend [N];
  logic [DW-1:0] m_qa;
  logic [DW-1:0] m_qb;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_qa = '0;
    m_qb = '0;
  endtask

  // Value a reader of register a should see this cycle.
  function automatic logic [DW-1:0] ref_read(
      input int a, input bit we, input int wr,
      input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (we && wr == a) return wd;
    return m_reg[a];
  endfunction

  task automatic step(input string tag,
                      input int rs, input int rt,
                      input bit we, input int rd,
                      input logic [DW-1:0] wd,
                      input bit iv, input int ird);
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    bit            ha;
    bit            hb;
    @(negedge clk);
    b0.rs        = AW'(rs);
    b0.rt        = AW'(rt);
    b0.rd        = AW'(rd);
    b0.writedata = wd;
    b0.regwrite  = we;
    b0.issue_vld = iv;
    b0.issue_rd  = AW'(ird);
    #1;
    ea = ref_read(rs, we, rd, wd);
    eb = ref_read(rt, we, rd, wd);
    ha = m_pend[rs] && !(we && rd == rs);
    hb = m_pend[rt] && !(we && rd == rt);
    chk({tag, "_A0"}, b0.A, ea);
    chk({tag, "_B0"}, b0.B, eb);
    chk({tag, "_ha0"}, DW'(b0.hazard_a), DW'(ha));
    chk({tag, "_hb0"}, DW'(b0.hazard_b), DW'(hb));
    chk({tag, "_A1"}, b1.A, m_qa);
    chk({tag, "_B1"}, b1.B, m_qb);
    chk({tag, "_ha1"}, DW'(b1.hazard_a), DW'(ha));
    chk({tag, "_hb1"}, DW'(b1.hazard_b), DW'(hb));
    @(posedge clk);
    if (we && rd != 0) begin
      m_reg[rd]  = wd;
      m_pend[rd] = 1'b0;
    end
    if (iv && ird != 0) m_pend[ird] = 1'b1;
    m_qa = ea;
    m_qb = eb;
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 9) == 0) return $urandom_range(0, N - 1);
    return $urandom_range(0, 7);
  endfunction

  initial begin
    b0.rs = '0; b0.rt = '0; b0.rd = '0;
    b0.writedata = '0; b0.regwrite = 1'b0;
    b0.issue_vld = 1'b0; b0.issue_rd = '0;
    model_reset();

    // T1: reset state
    #2;
    chk("rst_A0", b0.A, '0);
    chk("rst_A1", b1.A, '0);
    chk("rst_B1", b1.B, '0);
    chk("rst_ha", DW'(b0.hazard_a), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step("t1", 7, 31, 0, 0, '0, 0, 0);
    step("t1b", 7, 31, 0, 0, '0, 0, 0);

    // T2: write then read, plus same-cycle bypass
    step("t2w", 3, 0, 1, 3, 32'd100, 0, 0);
    step("t2r", 0, 3, 0, 0, '0, 0, 0);
    step("t2r1", 0, 3, 0, 0, '0, 0, 0);

    // T3: hardwired zero register
    step("t3w", 0, 0, 1, 0, 32'd100, 1, 0);
    step("t3r", 0, 0, 0, 0, '0, 0, 0);

    // T4: scoreboard set, bypass satisfies, then cleared
    step("t4i", 0, 0, 0, 0, '0, 1, 6);
    step("t4h", 6, 0, 0, 0, '0, 0, 0);
    step("t4w", 6, 6, 1, 6, 32'd100, 0, 0);
    step("t4c", 6, 0, 0, 0, '0, 0, 0);

    // T5: write and issue to one register on the same edge
    step("t5", 0, 5, 1, 5, 32'd77, 1, 5);
    step("t5h", 0, 5, 0, 0, '0, 0, 0);

    // T6: asynchronous reset between edges
    step("t6w", 0, 0, 1, 4, 32'd55, 0, 0);
    step("t6i", 0, 0, 0, 0, '0, 1, 4);
    step("t6p", 4, 4, 0, 0, '0, 0, 0);
    @(negedge clk);
    b0.rs = AW'(4); b0.rt = AW'(4);
    b0.regwrite = 1'b0; b0.issue_vld = 1'b0;
    #1;
    chk("t6pre_ha", DW'(b0.hazard_a), 32'd1);
    chk("t6pre_A0", b0.A, 32'd55);
    rst_n = 1'b0;
    #1;
    chk("t6_A0", b0.A, '0);
    chk("t6_A1", b1.A, '0);
    chk("t6_ha0", DW'(b0.hazard_a), '0);
    chk("t6_hb1", DW'(b1.hazard_b), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("t6post", 4, 4, 0, 0, '0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", pick_addr(), pick_addr(),
           bit'($urandom_range(0, 1)), pick_addr(), $urandom(),
           ($urandom_range(0, 2) == 0), pick_addr());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
